// File: rtl/mat_pkg.sv
// rtl/mat_pkg.sv - shared matrix constants, scheduler state type and index helper
package mat_pkg;

    localparam int MAT_ELEMS = 9;
    localparam int MAT_W     = 32;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT,
        RESP
    } sched_state_t;

    // Index of the set bit in a one-hot vector of up to eight requesters.
    function automatic int onehot2idx(input logic [7:0] oh);
        int idx;
        idx = 0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting after the last winner
module rr_arbiter import mat_pkg::*; #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic [N_REQ-1:0] pick,
    output logic [IDX_W-1:0] pick_idx
);

    always_comb begin
        int   idx;
        logic found;
        pick     = '0;
        pick_idx = '0;
        found    = 1'b0;
        idx      = 0;
        // Offsets 1..N_REQ visit every requester once, the previous winner last.
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(last) + k) % N_REQ;
            if (!found && req[idx]) begin
                found     = 1'b1;
                pick[idx] = 1'b1;
                pick_idx  = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/add_m_sched.sv
// rtl/add_m_sched.sv - round-robin scheduler sharing one add_m engine with a watchdog
module add_m_sched import mat_pkg::*; #(
    parameter int N_REQ   = 4,
    parameter int ELEMS   = MAT_ELEMS,
    parameter int W       = MAT_W,
    parameter int TIMEOUT = 1024
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*ELEMS*W-1:0] req_a,
    input  logic [N_REQ*ELEMS*W-1:0] req_b,
    output logic [N_REQ-1:0]         gnt,
    output logic [N_REQ-1:0]         ack,
    output logic                     err,
    output logic [ELEMS*W-1:0]       res_c,
    output logic                     sched_busy,
    output logic                     eng_start,
    output logic [ELEMS*W-1:0]       eng_a,
    output logic [ELEMS*W-1:0]       eng_b,
    input  logic [ELEMS*W-1:0]       eng_c,
    input  logic                     eng_busy,
    input  logic                     eng_done
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int OPW   = ELEMS * W;
    localparam int CNT_W = $clog2(TIMEOUT);

    sched_state_t     state;
    sched_state_t     next_state;
    logic [IDX_W-1:0] last;
    logic [IDX_W-1:0] owner;
    logic [N_REQ-1:0] pick;
    logic [IDX_W-1:0] pick_idx;
    logic [CNT_W-1:0] wdog;
    logic             wdog_term;
    logic [7:0]       gnt_ext;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req      (req),
        .last     (last),
        .pick     (pick),
        .pick_idx (pick_idx)
    );

    assign gnt_ext   = 8'(gnt);
    assign owner     = IDX_W'(onehot2idx(gnt_ext));
    assign wdog_term = (wdog == CNT_W'(TIMEOUT - 1));

    always_comb begin
        next_state = state;
        eng_start  = 1'b0;
        ack        = '0;
        case (state)
            IDLE: begin
                if (|req) next_state = LAUNCH;
            end
            LAUNCH: begin
                if (!eng_busy) begin
                    eng_start  = 1'b1;
                    next_state = WAIT;
                end
            end
            WAIT: begin
                if (eng_done || wdog_term) next_state = RESP;
            end
            RESP: begin
                ack        = gnt;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign sched_busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            last  <= IDX_W'(N_REQ - 1);
            gnt   <= '0;
            eng_a <= '0;
            eng_b <= '0;
            res_c <= '0;
            err   <= 1'b0;
            wdog  <= '0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    if (|req) begin
                        gnt   <= pick;
                        eng_a <= req_a[int'(pick_idx)*OPW +: OPW];
                        eng_b <= req_b[int'(pick_idx)*OPW +: OPW];
                    end
                end
                LAUNCH: wdog <= '0;
                WAIT: begin
                    wdog <= wdog + 1'b1;
                    // A done arriving on the terminal count still counts as success.
                    if (eng_done) begin
                        res_c <= eng_c;
                        err   <= 1'b0;
                    end else if (wdog_term) begin
                        res_c <= '0;
                        err   <= 1'b1;
                    end
                end
                RESP: begin
                    last <= owner;
                    gnt  <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_add_m_sched.sv
// tb/tb_add_m_sched.sv - self-checking bench with a transaction-level scheduler model
module tb_add_m_sched;

    localparam int N  = 4;
    localparam int E  = 9;
    localparam int W  = 32;
    localparam int TO = 16;
    localparam int OW = E * W;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N*OW-1:0] req_a = '0;
    logic [N*OW-1:0] req_b = '0;
    logic [N-1:0]    gnt;
    logic [N-1:0]    ack;
    logic            err;
    logic [OW-1:0]   res_c;
    logic            sched_busy;
    logic            eng_start;
    logic [OW-1:0]   eng_a;
    logic [OW-1:0]   eng_b;
    logic [OW-1:0]   eng_c = '0;
    logic            eng_busy = 1'b0;
    logic            eng_done = 1'b0;

    add_m_sched #(.N_REQ(N), .ELEMS(E), .W(W), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .req_a      (req_a),
        .req_b      (req_b),
        .gnt        (gnt),
        .ack        (ack),
        .err        (err),
        .res_c      (res_c),
        .sched_busy (sched_busy),
        .eng_start  (eng_start),
        .eng_a      (eng_a),
        .eng_b      (eng_b),
        .eng_c      (eng_c),
        .eng_busy   (eng_busy),
        .eng_done   (eng_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [OW-1:0] madd(input logic [OW-1:0] a, input logic [OW-1:0] b);
        logic [OW-1:0] s;
        for (int k = 0; k < E; k++) s[k*W +: W] = a[k*W +: W] + b[k*W +: W];
        return s;
    endfunction

    function automatic int rr(input int last_w, input logic [N-1:0] r);
        for (int k = 1; k <= N; k++) begin
            if (r[(last_w + k) % N]) return (last_w + k) % N;
        end
        return -1;
    endfunction

    function automatic int idx_of(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Engine stand-in: sums the latched operands and reports done after lat cycles.
    int            lat = 2;
    bit            hang = 1'b0;
    bit            spur = 1'b0;
    bit            running = 1'b0;
    int            cnt = 0;
    bit            s_seen;
    bit            r_seen;
    logic [OW-1:0] st_sum = '0;

    always begin
        @(negedge clk);
        s_seen = eng_start && !reset;
        r_seen = reset;
        if (eng_start) st_sum = madd(eng_a, eng_b);
        @(posedge clk);
        #2;
        eng_done = 1'b0;
        if (r_seen) begin
            running = 1'b0;
        end else begin
            if (running) begin
                cnt--;
                if (cnt == 0) begin
                    running  = 1'b0;
                    eng_done = 1'b1;
                    eng_c    = st_sum;
                end
            end
            if (s_seen && !hang) begin
                running = 1'b1;
                cnt     = lat;
            end
            if (spur) begin
                eng_done = 1'b1;
                spur     = 1'b0;
            end
        end
    end

    // Transaction model: one job at a time, predicted from requests and engine events.
    bit            rst_seen = 1'b0;
    int            m_last = N - 1;
    logic [OW-1:0] m_res = '0;
    bit            job = 1'b0;
    int            j_own = 0;
    logic [OW-1:0] j_a, j_b;
    bit            j_started = 1'b0;
    int            j_start = 0;
    bit            pend = 1'b0;
    int            p_own = 0;
    logic [OW-1:0] p_a, p_b;
    bit            ackx = 1'b0;
    bit            ackx_err;
    logic [OW-1:0] ackx_res;
    bit            ackn;
    bit            ackn_err;
    logic [OW-1:0] ackn_res;
    bit            exp_s;
    logic [N-1:0]  exp_g;

    int            ack_cnt = 0;
    int            n_start = 0;
    int            gnt_hist[$];
    logic [W-1:0]  res0_hist[$];
    int            last_grant_cyc = 0;
    int            last_start_cyc = 0;
    int            last_ack_cyc = 0;
    int            last_ack_own = -1;
    logic          last_err = 1'b0;
    logic [OW-1:0] last_res = '0;

    always @(negedge clk) begin
        if (rst_seen) begin
            chk("rst_gnt", OW'(gnt), '0);
            chk("rst_ack", OW'(ack), '0);
            chk("rst_err", OW'(err), '0);
            chk("rst_res", res_c, '0);
            chk("rst_busy", OW'(sched_busy), '0);
            chk("rst_start", OW'(eng_start), '0);
            chk("rst_eng_a", eng_a, '0);
            chk("rst_eng_b", eng_b, '0);
            m_last = N - 1;
            m_res  = '0;
            job    = 1'b0;
            pend   = 1'b0;
            ackx   = 1'b0;
        end
        if (ackx) begin
            chk("ack_owner", OW'(ack), OW'(1 << j_own));
            chk("ack_err", OW'(err), OW'(ackx_err));
            chk("ack_res", res_c, ackx_res);
            m_res = ackx_res;
            ack_cnt++;
            last_ack_cyc = cyc;
            last_ack_own = idx_of(ack);
            last_err     = err;
            last_res     = res_c;
            res0_hist.push_back(res_c[W-1:0]);
        end else begin
            chk("ack_idle", OW'(ack), '0);
            chk("res_hold", res_c, m_res);
        end
        if (pend) begin
            job       = 1'b1;
            j_own     = p_own;
            j_a       = p_a;
            j_b       = p_b;
            j_started = 1'b0;
            pend      = 1'b0;
            chk("latch_a", eng_a, p_a);
            chk("latch_b", eng_b, p_b);
            gnt_hist.push_back(idx_of(gnt));
            last_grant_cyc = cyc;
        end
        exp_g = job ? N'(1 << j_own) : '0;
        chk("gnt", OW'(gnt), OW'(exp_g));
        chk("sched_busy", OW'(sched_busy), OW'(job));
        exp_s = job && !j_started && !ackx && !eng_busy;
        chk("eng_start", OW'(eng_start), OW'(exp_s));
        if (eng_start) n_start++;
        if (exp_s) begin
            j_started      = 1'b1;
            j_start        = cyc;
            last_start_cyc = cyc;
        end
        ackn = 1'b0;
        if (job && j_started && cyc > j_start && !ackx) begin
            if (eng_done) begin
                ackn     = 1'b1;
                ackn_err = 1'b0;
                ackn_res = madd(j_a, j_b);
            end else if (cyc - j_start == TO) begin
                ackn     = 1'b1;
                ackn_err = 1'b1;
                ackn_res = '0;
            end
        end
        if (!job && !reset && |req) begin
            pend  = 1'b1;
            p_own = rr(m_last, req);
            p_a   = req_a[p_own*OW +: OW];
            p_b   = req_b[p_own*OW +: OW];
        end
        if (ackx) begin
            m_last = j_own;
            job    = 1'b0;
        end
        ackx     = ackn;
        ackx_err = ackn_err;
        ackx_res = ackn_res;
        rst_seen = reset;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_acks(input int n, input int budget);
        int target;
        target = ack_cnt + n;
        for (int i = 0; i < budget && ack_cnt < target; i++) tick();
        chk("ack_arrived", OW'(ack_cnt >= target), OW'(1));
    endtask

    int            exp_order[5] = '{0, 1, 2, 3, 0};
    int            exp_res0[5]  = '{0, 2, 4, 6, 0};
    logic [OW-1:0] all10;
    int            a0;

    initial begin
        repeat (3) tick();
        @(negedge clk);
        chk("reset_gnt", OW'(gnt), '0);
        chk("reset_busy", OW'(sched_busy), '0);
        chk("reset_res", res_c, '0);
        tick();
        reset = 1'b0;

        // Single requester, A=1..9 B=9..1.
        for (int k = 0; k < E; k++) begin
            req_a[k*W +: W] = W'(k + 1);
            req_b[k*W +: W] = W'(9 - k);
            all10[k*W +: W] = W'(10);
        end
        lat = 3;
        req = 4'b0001;
        wait_acks(1, 100);
        req = '0;
        chk("t1_first_grant", OW'(gnt_hist[0]), OW'(0));
        chk("t1_res_10", last_res, all10);
        chk("t1_err", OW'(last_err), '0);
        chk("t1_one_start", OW'(n_start), OW'(1));

        // A stray done while idle must not produce an ack.
        spur = 1'b1;
        repeat (4) tick();

        // Four simultaneous requesters held high.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < E; k++) begin
                req_a[(i*E + k)*W +: W] = W'(i);
                req_b[(i*E + k)*W +: W] = W'(i);
            end
        end
        gnt_hist.delete();
        res0_hist.delete();
        lat = 2;
        req = 4'b1111;
        wait_acks(5, 300);
        req = '0;
        chk("t2_hist_len", OW'(gnt_hist.size()), OW'(5));
        for (int i = 0; i < 5 && i < gnt_hist.size() && i < res0_hist.size(); i++) begin
            chk($sformatf("t2_order%0d", i), OW'(gnt_hist[i]), OW'(exp_order[i]));
            chk($sformatf("t2_res%0d", i), OW'(res0_hist[i]), OW'(exp_res0[i]));
        end

        // Engine busy for five cycles after the grant.
        req      = 4'b0010;
        eng_busy = 1'b1;
        repeat (6) tick();
        eng_busy = 1'b0;
        wait_acks(1, 100);
        req = '0;
        chk("t3_start_delay", OW'(last_start_cyc - last_grant_cyc), OW'(5));
        chk("t3_owner", OW'(last_ack_own), OW'(1));

        // Watchdog abort, then a normal job.
        hang = 1'b1;
        req  = 4'b0001;
        wait_acks(1, 100);
        req  = '0;
        hang = 1'b0;
        chk("t4_wd_latency", OW'(last_ack_cyc - last_start_cyc), OW'(17));
        chk("t4_wd_err", OW'(last_err), OW'(1));
        chk("t4_wd_res", last_res, '0);
        lat = 1;
        req = 4'b0100;
        wait_acks(1, 100);
        req = '0;
        chk("t4_next_owner", OW'(last_ack_own), OW'(2));
        chk("t4_next_err", OW'(last_err), '0);
        chk("t4_next_res", OW'(last_res[W-1:0]), OW'(4));

        // Reset while waiting aborts the job and restores the round-robin pointer.
        hang = 1'b1;
        req  = 4'b0010;
        repeat (5) tick();
        req   = '0;
        a0    = ack_cnt;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        hang  = 1'b0;
        repeat (3) tick();
        chk("t5_no_ack", OW'(ack_cnt), OW'(a0));
        req = 4'b1100;
        wait_acks(1, 100);
        chk("t5_first_after_rst", OW'(last_ack_own), OW'(2));
        wait_acks(1, 100);
        req = '0;
        chk("t5_second", OW'(last_ack_own), OW'(3));

        // Request dropped right after the grant still completes.
        lat = 4;
        req = 4'b1000;
        for (int i = 0; i < 20 && gnt == '0; i++) tick();
        req = '0;
        wait_acks(1, 100);
        chk("t6_drop_owner", OW'(last_ack_own), OW'(3));
        chk("t6_drop_res", OW'(last_res[W-1:0]), OW'(6));

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1);
    end

endmodule
